// File: rtl/ntt_stage_scheduler.sv
// Address/twiddle sequencer for one in-place radix-2 NTT pass over a dual-port coefficient RAM.
// Reads are issued from a stage/butterfly counter; write-backs replay them PIPE_DELAY cycles later.
module ntt_stage_scheduler #(
    parameter int RING_SIZE  = 256,
    parameter int PIPE_DELAY = 11,
    parameter int ADDR_W     = $clog2(RING_SIZE),
    parameter int LOG_N      = $clog2(RING_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-2:0] tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b
);
    // Handshake: start is a level sampled only in IDLE; rd_en/wr_en are single-cycle
    // strobes with no back-pressure, and the addresses are valid exactly when the strobe is high.
    localparam int JW = ADDR_W - 1;
    localparam int DW = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(RING_SIZE / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_DELAY - 1);
    localparam logic [3:0]    S_LAST = 4'(LOG_N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_n;
    logic [JW-1:0]   j, j_n;
    logic [3:0]      stage_n;
    logic [DW-1:0]   drain, drain_n;

    function automatic logic [ADDR_W-1:0] low_mask(input logic [3:0] s);
        return (ADDR_W'(1) << s) - ADDR_W'(1);
    endfunction

    // g*2m + k: bits above the stage position shift up by one, the low k bits stay put.
    function automatic logic [ADDR_W-1:0] upper_addr(input logic [JW-1:0] jj, input logic [3:0] s);
        logic [ADDR_W-1:0] jw;
        logic [ADDR_W-1:0] m;
        jw = {1'b0, jj};
        m  = low_mask(s);
        return ((jw & ~m) << 1) | (jw & m);
    endfunction

    function automatic logic [JW-1:0] twiddle(input logic [JW-1:0] jj, input logic [3:0] s);
        logic [ADDR_W-1:0] m;
        logic [JW-1:0]     k;
        m = low_mask(s);
        k = jj & m[JW-1:0];
        return k << (S_LAST - s);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            j     <= '0;
            stage <= '0;
            drain <= '0;
        end else begin
            state <= state_n;
            j     <= j_n;
            stage <= stage_n;
            drain <= drain_n;
        end
    end

    always_comb begin
        state_n = state;
        j_n     = j;
        stage_n = stage;
        drain_n = drain;
        case (state)
            IDLE: begin
                j_n     = '0;
                stage_n = '0;
                drain_n = '0;
                if (start) state_n = ISSUE;
            end
            ISSUE: begin
                if (j == J_LAST) begin
                    j_n     = '0;
                    drain_n = '0;
                    state_n = DRAIN;
                end else begin
                    j_n = j + JW'(1);
                end
            end
            DRAIN: begin
                // The last write of this stage lands in the final drain cycle.
                if (drain == D_LAST) begin
                    drain_n = '0;
                    if (stage == S_LAST) begin
                        state_n = DONE;
                    end else begin
                        stage_n = stage + 4'd1;
                        state_n = ISSUE;
                    end
                end else begin
                    drain_n = drain + DW'(1);
                end
            end
            DONE: begin
                stage_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Read outputs are registered from the next-state values so they line up with ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            rd_en <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                rd_addr_a <= upper_addr(j_n, stage_n);
                rd_addr_b <= upper_addr(j_n, stage_n) + (ADDR_W'(1) << stage_n);
                tw_addr   <= twiddle(j_n, stage_n);
            end
        end
    end

    logic [PIPE_DELAY-1:0] pipe_v;
    logic [ADDR_W-1:0]     pipe_a [PIPE_DELAY];
    logic [ADDR_W-1:0]     pipe_b [PIPE_DELAY];

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en;
            pipe_a[0] <= rd_addr_a;
            pipe_b[0] <= rd_addr_b;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    assign wr_en     = pipe_v[PIPE_DELAY-1];
    assign wr_addr_a = pipe_a[PIPE_DELAY-1];
    assign wr_addr_b = pipe_b[PIPE_DELAY-1];
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: three configurations checked cycle by cycle against a
// schedule model derived from the stage timing formulas and the butterfly address rules.
module tb_ntt_stage_scheduler;
    localparam int N0 = 256, P0 = 11, A0 = $clog2(N0);
    localparam int N1 = 8,   P1 = 3,  A1 = $clog2(N1);
    localparam int N2 = 8,   P2 = 11, A2 = $clog2(N2);

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic        wr_en;
        logic [3:0]  stage;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] tw;
        logic [15:0] wa;
        logic [15:0] wb;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = 3'b000;
    obs_t       obs [3];

    int cfg_n [3] = '{N0, N1, N2};
    int cfg_p [3] = '{P0, P1, P2};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic busy0, done0, rd_en0, wr_en0; logic [3:0] stage0;
    logic [A0-1:0] ra0, rb0, wa0, wb0; logic [A0-2:0] tw0;
    logic busy1, done1, rd_en1, wr_en1; logic [3:0] stage1;
    logic [A1-1:0] ra1, rb1, wa1, wb1; logic [A1-2:0] tw1;
    logic busy2, done2, rd_en2, wr_en2; logic [3:0] stage2;
    logic [A2-1:0] ra2, rb2, wa2, wb2; logic [A2-2:0] tw2;

    ntt_stage_scheduler #(.RING_SIZE(N0), .PIPE_DELAY(P0)) u_dut0 (
        .clk(clk), .reset(rst), .start(start[0]), .busy(busy0), .done(done0), .stage(stage0),
        .rd_en(rd_en0), .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0),
        .wr_en(wr_en0), .wr_addr_a(wa0), .wr_addr_b(wb0));
    ntt_stage_scheduler #(.RING_SIZE(N1), .PIPE_DELAY(P1)) u_dut1 (
        .clk(clk), .reset(rst), .start(start[1]), .busy(busy1), .done(done1), .stage(stage1),
        .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
        .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1));
    ntt_stage_scheduler #(.RING_SIZE(N2), .PIPE_DELAY(P2)) u_dut2 (
        .clk(clk), .reset(rst), .start(start[2]), .busy(busy2), .done(done2), .stage(stage2),
        .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_addr(tw2),
        .wr_en(wr_en2), .wr_addr_a(wa2), .wr_addr_b(wb2));

    assign obs[0] = '{busy: busy0, done: done0, rd_en: rd_en0, wr_en: wr_en0, stage: stage0,
                      ra: 16'(ra0), rb: 16'(rb0), tw: 16'(tw0), wa: 16'(wa0), wb: 16'(wb0)};
    assign obs[1] = '{busy: busy1, done: done1, rd_en: rd_en1, wr_en: wr_en1, stage: stage1,
                      ra: 16'(ra1), rb: 16'(rb1), tw: 16'(tw1), wa: 16'(wa1), wb: 16'(wb1)};
    assign obs[2] = '{busy: busy2, done: done2, rd_en: rd_en2, wr_en: wr_en2, stage: stage2,
                      ra: 16'(ra2), rb: 16'(rb2), tw: 16'(tw2), wa: 16'(wa2), wb: 16'(wb2)};

    // ---------------- scoreboard state ----------------
    int n_checks = 0, n_pass = 0;
    bit act [3];
    int cyc [3];
    int hold_a [3], hold_b [3], hold_tw [3];
    bit just_rst;
    int rd_cnt [3], wr_cnt [3], done_cnt [3], done_at [3];
    int hist [256];
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int done_cycle(input int i);
        return $clog2(cfg_n[i]) * (cfg_n[i] / 2 + cfg_p[i]) + 1;
    endfunction

    // Butterfly j of stage s: pairs are m apart, groups of 2m, twiddle stride N/(2m).
    function automatic void ref_bfly(input int n, input int s, input int j,
                                     output int a, output int b, output int tw);
        int m;
        m  = 1 << s;
        a  = (j / m) * 2 * m + (j % m);
        b  = a + m;
        tw = (j % m) * (n / (2 * m));
    endfunction

    // Model of what the scheduler has accepted; cyc counts cycles since start was taken.
    always @(posedge clk) begin
        just_rst = rst;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                act[i] = 1'b0; cyc[i] = 0;
                hold_a[i] = 0; hold_b[i] = 0; hold_tw[i] = 0;
            end else if (act[i]) begin
                if (cyc[i] == done_cycle(i)) begin act[i] = 1'b0; cyc[i] = 0; end
                else cyc[i]++;
            end else if (start[i]) begin
                act[i] = 1'b1; cyc[i] = 1;
            end
        end
    end

    task automatic check_inst(input int i);
        int n, p, h, per, d, c, s, off, cw, a, b, tw;
        bit e_busy, e_done, e_rd, e_wr;
        int e_stage, e_wa, e_wb;
        obs_t o;
        string pfx;
        o = obs[i];
        pfx = $sformatf("i%0d", i);
        n = cfg_n[i]; p = cfg_p[i]; h = n / 2; per = h + p; d = done_cycle(i);
        e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_stage = 0; e_wa = 0; e_wb = 0;
        if (act[i]) begin
            c = cyc[i];
            e_busy = 1;
            if (c == d) begin
                e_done = 1; e_stage = $clog2(n) - 1;
            end else begin
                s = (c - 1) / per; off = (c - 1) % per; e_stage = s;
                if (off < h) begin
                    e_rd = 1;
                    ref_bfly(n, s, off, a, b, tw);
                    hold_a[i] = a; hold_b[i] = b; hold_tw[i] = tw;
                end
            end
            cw = c - p;
            if (cw >= 1 && cw < d && ((cw - 1) % per) < h) begin
                e_wr = 1;
                ref_bfly(n, (cw - 1) / per, (cw - 1) % per, e_wa, e_wb, tw);
            end
        end
        chk({pfx, "_busy"}, 32'(o.busy), 32'(e_busy));
        chk({pfx, "_done"}, 32'(o.done), 32'(e_done));
        chk({pfx, "_stage"}, 32'(o.stage), 32'(e_stage));
        chk({pfx, "_rd_en"}, 32'(o.rd_en), 32'(e_rd));
        chk({pfx, "_rd_a"}, 32'(o.ra), 32'(hold_a[i]));
        chk({pfx, "_rd_b"}, 32'(o.rb), 32'(hold_b[i]));
        chk({pfx, "_tw"}, 32'(o.tw), 32'(hold_tw[i]));
        chk({pfx, "_wr_en"}, 32'(o.wr_en), 32'(e_wr));
        if (e_wr || just_rst) begin
            chk({pfx, "_wr_a"}, 32'(o.wa), 32'(e_wa));
            chk({pfx, "_wr_b"}, 32'(o.wb), 32'(e_wb));
        end
        if (o.rd_en === 1'b1) begin
            rd_cnt[i]++;
            if (i == 0) begin hist[o.ra[7:0]]++; hist[o.rb[7:0]]++; end
            if (i == 1) begin obs_q.push_back(o.ra); obs_q.push_back(o.rb); obs_q.push_back(o.tw); end
        end
        if (o.wr_en === 1'b1) wr_cnt[i]++;
        if (o.done === 1'b1) begin done_cnt[i]++; done_at[i] = cyc[i]; end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) check_inst(i);
    end

    // ---------------- driver tasks ----------------
    // mode 0: single pulse, 1: random start noise while busy, 2: start held high all run.
    task automatic run_one(input int i, input int mode);
        int budget;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start[i] = 1'b1;
        budget = 0;
        while (budget < 5000) begin
            @(negedge clk);
            budget++;
            if (!act[i]) break;
            case (mode)
                1:       start[i] = 1'($urandom_range(0, 1));
                2:       start[i] = 1'b1;
                default: start[i] = 1'b0;
            endcase
        end
        start[i] = 1'b0;
        chk($sformatf("i%0d_run_timeout", i), 32'(act[i]), 32'd0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            rd_cnt[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
        end
        for (int k = 0; k < 256; k++) hist[k] = 0;
        obs_q.delete();
    endtask

    task automatic check_counts(input int i, input int exp_done_at);
        int tot;
        tot = $clog2(cfg_n[i]) * cfg_n[i] / 2;
        chk($sformatf("i%0d_done_pulses", i), 32'(done_cnt[i]), 32'd1);
        chk($sformatf("i%0d_rd_pulses", i), 32'(rd_cnt[i]), 32'(tot));
        chk($sformatf("i%0d_wr_pulses", i), 32'(wr_cnt[i]), 32'(tot));
        chk($sformatf("i%0d_done_cycle", i), 32'(done_at[i]), 32'(exp_done_at));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tbl_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int tbl_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int tbl_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int target, budget, bad;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_counts();

        // Concurrent runs: big config with noisy start, N=8 with start held, long drain.
        fork
            run_one(0, 1);
            run_one(1, 2);
            run_one(2, 0);
        join
        check_counts(0, 1113);
        check_counts(1, 22);
        check_counts(2, 46);
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(16'(tbl_a[k])); exp_q.push_back(16'(tbl_b[k])); exp_q.push_back(16'(tbl_t[k]));
        end
        chk("i1_seq_len", 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk("i1_seq_entry", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();

        // Repeat runs on the small configs give the same schedule again.
        clear_counts();
        fork
            run_one(1, 1);
            run_one(2, 2);
        join
        check_counts(1, 22);
        check_counts(2, 46);

        // Abort the big config somewhere in stage 3 with a synchronous reset.
        clear_counts();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        target = 1 + 3 * (N0 / 2 + P0) + $urandom_range(0, N0 / 2 + P0 - 1);
        budget = 0;
        while (act[0] && cyc[0] < target && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        chk("i0_reached_stage3", 32'(cyc[0] >= target), 32'd1);
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("i0_abort_done", 32'(done_cnt[0]), 32'd0);
        chk("i0_abort_busy", 32'(obs[0].busy), 32'd0);

        // Fresh full run after the abort: pulse totals and per-address read coverage.
        clear_counts();
        run_one(0, 0);
        check_counts(0, 1113);
        bad = 0;
        for (int k = 0; k < 256; k++) if (hist[k] != 8) bad++;
        chk("i0_addr_coverage", 32'(bad), 32'd0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/ntt_stage_scheduler.md
Name: ntt_stage_scheduler

Overview:
- Sequences one in-place iterative radix-2 NTT pass over the coefficient RAM.
- Starts from bit-reversed input and runs LOG_N stages of N/2 butterflies each.
- Per butterfly it issues two read addresses and a twiddle-ROM index. It then returns the matching write addresses exactly PIPE_DELAY cycles later, aligned with the butterfly datapath output (integer multiply plus modular reduction).
- Inserts a drain gap between stages so stage s+1 never reads a location before stage s has written it.

Parameters:
- RING_SIZE, 256, N = number of coefficients; must be a power of two, ≥ 4.
- PIPE_DELAY, 11, butterfly read-to-write latency in cycles; must be ≥ 1.
- ADDR_W, $clog2(RING_SIZE), coefficient address width (derived).
- LOG_N, $clog2(RING_SIZE), number of stages (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse at the end of the transform
- stage  out  4  current stage index, 0..LOG_N-1
- rd_en  out  1  butterfly issue strobe
- rd_addr_a  out  ADDR_W  upper-input address
- rd_addr_b  out  ADDR_W  lower-input address
- tw_addr  out  ADDR_W-1  twiddle ROM index
- wr_en  out  1  write-back strobe, equal to rd_en delayed by PIPE_DELAY
- wr_addr_a  out  ADDR_W  rd_addr_a delayed by PIPE_DELAY
- wr_addr_b  out  ADDR_W  rd_addr_b delayed by PIPE_DELAY

Behaviour:
- Reset:
  - state=IDLE, stage=0, butterfly counter j=0.
  - All outputs 0.
  - All PIPE_DELAY delay-line valid bits cleared.
  - Reset asserted mid-transform aborts it: no wr_en in the cycle after reset, and done is never asserted.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start=1, go to ISSUE with stage=0, j=0.
  - ISSUE: rd_en=1 every cycle. j increments 0..N/2-1. When j==N/2-1, go to DRAIN and clear j.
  - DRAIN: lasts exactly PIPE_DELAY cycles, counted by a drain counter. The final write of the stage lands on the last DRAIN cycle. On exit:
    - if stage==LOG_N-1, go to DONE;
    - otherwise stage+1, back to ISSUE.
  - DONE: done=1 for one cycle, then IDLE. stage holds LOG_N-1 through DONE and returns to 0 in IDLE.
- Address arithmetic, registered outputs valid in the same cycle as rd_en, with m = 2^stage:
  - k = j & (m-1); group g = j >> stage.
  - rd_addr_a = g*2m + k; rd_addr_b = rd_addr_a + m.
  - tw_addr = k << (LOG_N-1-stage).
  - All values are unsigned and fit their widths with no wrap.
- Write-back path:
  - A PIPE_DELAY-deep shift register of {valid, addr_a, addr_b}.
  - wr_* at cycle t+PIPE_DELAY equals rd_* at cycle t.
  - Each stage's last write lands one cycle before the next stage's first read. RAM write-then-read in consecutive cycles is therefore safe.
- Timing:
  - start is accepted at cycle 0. Stage s issues in cycles 1+s*(N/2+PIPE_DELAY) .. s*(N/2+PIPE_DELAY)+N/2.
  - done occurs at cycle LOG_N*(N/2+PIPE_DELAY)+1.
- start while busy is ignored. start in the same cycle as DONE is ignored; it must be reasserted in IDLE.
- rd_en and wr_en may both be high in the same cycle only within a stage when PIPE_DELAY < N/2. The RAM is dual-port (2R/2W); no arbitration is needed.
- Outside ISSUE, rd_en=0 and the rd_*/tw_addr outputs hold their last value.

Test Plan:
- Address sequence, N=8, PIPE_DELAY=3. rd pairs/tw:
  - stage0: (0,1)/0, (2,3)/0, (4,5)/0, (6,7)/0.
  - stage1: (0,2)/0, (1,3)/2, (4,6)/0, (5,7)/2.
  - stage2: (0,4)/0, (1,5)/1, (2,6)/2, (3,7)/3.
  - done at cycle 22.
- Write alignment, same config: each wr_en/wr_addr pair equals the rd pair from 3 cycles earlier. There are exactly 12 wr_en pulses. The stage0 last write is at cycle 7 and the stage1 first read is at cycle 8.
- Long-latency drain, N=8, PIPE_DELAY=11: no rd_en while any write of the prior stage is pending; done at cycle 46.
- Mid-run reset, N=256, PIPE_DELAY=11: assert reset during stage 3 → next cycle IDLE, busy=0, rd_en=wr_en=0, no done. A fresh start then produces the full sequence from stage0.
- start held high throughout a run: only one transform executes and done pulses once. A second start after done begins a new run with identical addresses.
- Default N=256, PIPE_DELAY=11: 1024 rd_en and 1024 wr_en pulses. Every address 0..255 is read exactly 8 times per port pair. done at cycle 8*(128+11)+1 = 1113.
